ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
Burst access controller directly upstream of the 256x32 synchronous RAM (ports clk, addr, dataIn, wrEnable, dataOut).
- Accepts one read or write burst command over a valid/ready handshake.
- Sequences the RAM address and write-enable, one beat per clock.
- Moves data over separate write-data and read-data valid/ready streams.
- Buffers read data so that consumer backpressure never loses a RAM word.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 32, RAM word width.
RD_LAT, 1, RAM read latency in cycles from addr to dataOut valid.
RBUF_DEPTH, 2, read-return buffer entries; must be >= RD_LAT+1.

Ports:
clk  in  1  rising-edge clock shared with the RAM.
rst_n  in  1  asynchronous active-low reset.
reqValid  in  1  command valid.
reqReady  out  1  command accepted when reqValid && reqReady.
reqWrite  in  1  1 = write burst, 0 = read burst.
reqAddr  in  ADDR_W  burst start address.
reqLen  in  8  beats minus one (0 = 1 beat, 255 = 256 beats).
wdValid  in  1  write data valid.
wdReady  out  1  write data accepted.
wdData  in  DATA_W  write beat.
rdValid  out  1  read data valid.
rdReady  in  1  read data consumed.
rdData  out  DATA_W  read beat.
rdLast  out  1  marks the final beat of a read burst.
memAddr  out  ADDR_W  to RAM addr.
memDataIn  out  DATA_W  to RAM dataIn.
memWrEnable  out  1  to RAM wrEnable.
memDataOut  in  DATA_W  from RAM dataOut.
busy  out  1  high from command accept until the last beat completes.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; read buffer emptied; in-flight pipeline cleared.
  - Outputs: reqReady=0, wdReady=0, rdValid=0, rdLast=0, memWrEnable=0, memAddr=0, memDataIn=0, busy=0.
  - reqReady rises the first cycle after rst_n deasserts.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - reqReady=1.
  - On handshake: latch addr/len/write into curAddr and beatsLeft, assert busy, go to WRITE or READ.
- WRITE:
  - wdReady=1.
  - Each cycle with wdValid: memWrEnable=1, memAddr=curAddr, memDataIn=wdData.
  - curAddr increments; beatsLeft decrements.
  - Cycles without wdValid: memWrEnable=0, no address change.
  - After the last beat is accepted: go to IDLE next cycle, busy=0.
  - Write beats reach the RAM on the same edge they are accepted.
- READ:
  - Issue a read (memAddr=curAddr, curAddr++) only when buffered + in-flight entries < RBUF_DEPTH.
  - memWrEnable=0 throughout.
  - Capture memDataOut RD_LAT cycles after issue into the buffer.
  - After the last issue: go to DRAIN.
- DRAIN:
  - Wait until in-flight count is 0 and the buffer is empty, then go to IDLE.
  - busy deasserts the cycle after the last rdValid && rdReady.
- Read stream:
  - FIFO order.
  - rdData/rdValid are held stable until rdReady.
  - rdLast=1 only with the final beat of the burst.
  - Minimum latency from read command accept to first rdValid is 1+RD_LAT cycles.
  - With rdReady held high, throughput is 1 beat/cycle.
- Address arithmetic: curAddr wraps 0xFF -> 0x00 with no error. Burst length is independent of wrap.
- Command handling: no command is accepted while busy; reqReady=0 in all non-IDLE states.
- Simultaneous events: a buffer push and pop in the same cycle leaves the count unchanged. A full buffer with rdReady=1 may issue a new read in that same cycle.
- Mid-burst reset aborts immediately. Partially written words remain in RAM; no rdValid is seen after reset.
- memAddr holds its last value when idle.

Test Plan:
- Single write: req write addr 0x00 len 0, wdData 0xC0FFEE00 -> one cycle memWrEnable=1, memAddr=0x00, memDataIn=0xC0FFEE00; busy drops next cycle.
- Single read after that write: req read addr 0x00 len 0 -> rdValid with rdData=0xC0FFEE00, rdLast=1, 2 cycles after accept.
- Burst write/read: write addr 0x10 len 3 data 0x11,0x22,0x33,0x44 with wdValid gapped every other cycle; read back -> 0x11,0x22,0x33,0x44 in order, rdLast on the 4th beat.
- Wrap: write addr 0xFE len 3 -> memAddr sequence 0xFE,0xFF,0x00,0x01; readback matches.
- Backpressure: read len 7 with rdReady low for 5 cycles -> at most RBUF_DEPTH words buffered, no lost or duplicated beats, rdData stable while stalled.
- Reset mid-burst: assert rst_n=0 during the 3rd beat of a read len 7 -> all outputs at reset values immediately; after release reqReady=1, no stale rdValid.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst command sequencer for a single-port synchronous RAM: write beats go straight
// to the RAM; read beats return through a small FIFO that absorbs consumer stalls.
module ram_burst_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int RBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [7:0]        reqLen,
  input  logic              wdValid,
  output logic              wdReady,
  input  logic [DATA_W-1:0] wdData,
  output logic              rdValid,
  input  logic              rdReady,
  output logic [DATA_W-1:0] rdData,
  output logic              rdLast,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memWrEnable,
  input  logic [DATA_W-1:0] memDataOut,
  output logic              busy
);

  localparam int PTR_W = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(RBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [7:0]        beats_left;
  logic              req_ready_reg;
  logic              wd_ready_reg;
  logic              busy_reg;

  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;

  logic [DATA_W:0]   rbuf [RBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic wr_beat;
  logic issue;
  logic push;
  logic pop;
  int   inflight;
  int   occupancy;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_beat = wd_ready_reg && wdValid;
  assign push    = pipe_vld[RD_LAT-1];
  assign pop     = (count != '0) && rdReady;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(pipe_vld[i]);
  end

  // A pop this cycle frees a slot, so a full buffer can still issue while draining.
  assign occupancy = int'(count) + inflight;
  assign issue = (state == READ) &&
                 ((occupancy < RBUF_DEPTH) || (pop && occupancy <= RBUF_DEPTH));

  // Write beats and read issues drive the RAM combinationally so they land on the accepting edge.
  assign memWrEnable = wr_beat;
  assign memDataIn   = wr_beat ? wdData : '0;
  assign memAddr     = (wr_beat || issue) ? cur_addr : last_addr;

  assign reqReady = req_ready_reg;
  assign wdReady  = wd_ready_reg;
  assign busy     = busy_reg;
  assign rdValid  = (count != '0);
  assign rdData   = rbuf[rd_ptr][DATA_W-1:0];
  assign rdLast   = rdValid && rbuf[rd_ptr][DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      last_addr     <= '0;
      beats_left    <= '0;
      req_ready_reg <= 1'b0;
      wd_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if (wr_beat || issue) begin
        last_addr  <= cur_addr;
        cur_addr   <= cur_addr + ADDR_W'(1);
        beats_left <= beats_left - 8'd1;
      end
      case (state)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (reqValid && req_ready_reg) begin
            cur_addr      <= reqAddr;
            beats_left    <= reqLen;
            busy_reg      <= 1'b1;
            req_ready_reg <= 1'b0;
            wd_ready_reg  <= reqWrite;
            state         <= reqWrite ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_beat && beats_left == 8'd0) begin
            wd_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            req_ready_reg <= 1'b1;
            state         <= IDLE;
          end
        end
        READ: begin
          if (issue && beats_left == 8'd0) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == 0 && (count == '0 || (count == CNT_W'(1) && pop))) begin
            busy_reg      <= 1'b0;
            req_ready_reg <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency pipeline tracks which RAM outputs are real beats and which one is last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (beats_left == 8'd0);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) rbuf[wr_ptr] <= {pipe_last[RD_LAT-1], memDataOut};
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural 256x32 RAM; monitors pop
// expected write beats and read beats as the DUT presents them.
module tb_ram_burst_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reqValid, reqReady, reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [7:0]        reqLen;
  logic              wdValid, wdReady;
  logic [DATA_W-1:0] wdData;
  logic              rdValid, rdReady, rdLast;
  logic [DATA_W-1:0] rdData;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataIn, memDataOut;
  logic              memWrEnable, busy;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .RBUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqLen(reqLen),
    .wdValid(wdValid), .wdReady(wdReady), .wdData(wdData),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .rdLast(rdLast),
    .memAddr(memAddr), .memDataIn(memDataIn), .memWrEnable(memWrEnable),
    .memDataOut(memDataOut), .busy(busy)
  );

  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (memWrEnable) mem[memAddr] <= memDataIn;
    memDataOut <= mem[memAddr];
  end

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] wq[$];
  logic [DATA_W:0]          rq[$];
  bit                       mon_en = 1'b0;
  bit                       stalled = 1'b0;
  logic [DATA_W:0]          held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write-side monitor: every RAM write must match the next expected (addr,data).
  always @(negedge clk) begin
    if (mon_en && memWrEnable) begin
      logic [ADDR_W+DATA_W-1:0] e;
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexp_write: addr %0h data %0h with nothing expected", memAddr, memDataIn);
      end else begin
        e = wq.pop_front();
        check("wr_addr", 64'(memAddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", 64'(memDataIn), 64'(e[DATA_W-1:0]));
        $display("write beat addr=%0h data=%0h", memAddr, memDataIn);
      end
    end
  end

  // Read-side monitor: stalled data must hold, consumed beats pop the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rdValid) begin
      logic [DATA_W:0] e;
      if (stalled) check("rd_stable", 64'({rdLast, rdData}), 64'(held));
      if (rdReady) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_read: data %0h last %0b with nothing expected", rdData, rdLast);
        end else begin
          e = rq.pop_front();
          check("rd_data", 64'(rdData), 64'(e[DATA_W-1:0]));
          check("rd_last", 64'(rdLast), 64'(e[DATA_W]));
          $display("read beat data=%0h last=%0b", rdData, rdLast);
        end
      end
    end
    stalled = mon_en && rdValid && !rdReady;
    held    = {rdLast, rdData};
  end

  task automatic send_req(input bit w, input logic [7:0] a, input logic [7:0] len);
    bit ok = 1'b0;
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqLen = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (reqReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL req_timeout: reqReady 0 required 1"); end
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic write_beat(input logic [DATA_W-1:0] d, input bit gap);
    bit ok = 1'b0;
    wdValid = 1'b1; wdData = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wdReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL wd_timeout: wdReady 0 required 1"); end
    @(posedge clk); #1;
    wdValid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && rq.size() == 0 && wq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy %0b rq %0d wq %0d required idle and empty", busy, rq.size(), wq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reqReady"}, 64'(reqReady), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rdValid"}, 64'(rdValid), 64'd0);
    check({tag, "_rdLast"}, 64'(rdLast), 64'd0);
    check({tag, "_wdReady"}, 64'(wdReady), 64'd0);
    check({tag, "_memWrEnable"}, 64'(memWrEnable), 64'd0);
    check({tag, "_memAddr"}, 64'(memAddr), 64'd0);
    check({tag, "_memDataIn"}, 64'(memDataIn), 64'd0);
  endtask

  logic [DATA_W-1:0] burst_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [DATA_W-1:0] wrap_data  [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
  logic [ADDR_W-1:0] wrap_addr  [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [DATA_W-1:0] long_data  [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
                                        32'h1004, 32'h1005, 32'h1006, 32'h1007};

  initial begin
    int lat;
    int stray;
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqLen = '0;
    wdValid = 1'b0; wdData = '0; rdReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("reqReady_before_edge", 64'(reqReady), 64'd0);
    @(posedge clk); #1;
    check("reqReady_after_rst", 64'(reqReady), 64'd1);
    mon_en = 1'b1;

    // Single write
    send_req(1'b1, 8'h00, 8'd0);
    check("busy_during_write", 64'(busy), 64'd1);
    check("reqReady_busy", 64'(reqReady), 64'd0);
    wq.push_back({8'h00, 32'hC0FFEE00});
    write_beat(32'hC0FFEE00, 1'b0);
    check("busy_drop_write", 64'(busy), 64'd0);
    check("memAddr_hold", 64'(memAddr), 64'h00);

    // Single read with latency measurement
    rq.push_back({1'b1, 32'hC0FFEE00});
    send_req(1'b0, 8'h00, 8'd0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rdValid) break;
    end
    check("read_latency", 64'(lat), 64'd2);
    wait_idle();

    // Gapped burst write then readback
    send_req(1'b1, 8'h10, 8'd3);
    for (int i = 0; i < 4; i++) begin
      wq.push_back({8'h10 + 8'(i), burst_data[i]});
      write_beat(burst_data[i], 1'b1);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) rq.push_back({i == 3, burst_data[i]});
    send_req(1'b0, 8'h10, 8'd3);
    wait_idle();

    // Address wrap
    send_req(1'b1, 8'hFE, 8'd3);
    for (int i = 0; i < 4; i++) begin
      wq.push_back({wrap_addr[i], wrap_data[i]});
      write_beat(wrap_data[i], 1'b0);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) rq.push_back({i == 3, wrap_data[i]});
    send_req(1'b0, 8'hFE, 8'd3);
    wait_idle();

    // Backpressure: only two reads may be outstanding while the consumer stalls
    send_req(1'b1, 8'h20, 8'd7);
    for (int i = 0; i < 8; i++) begin
      wq.push_back({8'h20 + 8'(i), long_data[i]});
      write_beat(long_data[i], 1'b0);
    end
    wait_idle();
    rdReady = 1'b0;
    for (int i = 0; i < 8; i++) rq.push_back({i == 7, long_data[i]});
    send_req(1'b0, 8'h20, 8'd7);
    repeat (5) @(posedge clk);
    #1;
    check("stall_issue_bound", 64'(memAddr), 64'h21);
    check("stall_rdValid", 64'(rdValid), 64'd1);
    check("stall_head", 64'(rdData), 64'h1000);
    rdReady = 1'b1;
    wait_idle();

    // Reset mid-burst
    for (int i = 0; i < 8; i++) rq.push_back({i == 7, long_data[i]});
    send_req(1'b0, 8'h20, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reqReady_after_midrst", 64'(reqReady), 64'd1);
    mon_en = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdValid) stray++;
    end
    check("no_stale_rdValid", 64'(stray), 64'd0);
    @(posedge clk); #1;

    // Recovery read after reset
    rq.push_back({1'b1, 32'h1001});
    send_req(1'b0, 8'h21, 8'd0);
    wait_idle();

    check("wq_empty", 64'(wq.size()), 64'd0);
    check("rq_empty", 64'(rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
